cpu_bus_responder: RTL

CPU_BUS_RESPONDER -- requirements
Module: cpu_bus_responder

---
 rtl/cpu_bus_responder_if.sv | 47 ++++
 rtl/cpu_bus_responder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/cpu_bus_responder_if.sv
// CPU-side memory bus plus the decoded target selects, read data and
// completion strobes seen by the bus responder.
interface cpu_bus_responder_if;
  logic        cpu_mem_valid;
  logic [3:0]  cpu_wstrb;

  logic        cpu_ram_en;
  logic        vdp_en;
  logic        status_en;
  logic        dsp_en;
  logic        pad_en;
  logic        cop_ram_write_en;
  logic        flash_read_en;

  logic [31:0] cpu_ram_rdata;
  logic [31:0] status_rdata;
  logic [31:0] flash_rdata;
  logic [15:0] vdp_rdata;
  logic [15:0] dsp_rdata;
  logic [1:0]  pad_rdata;

  logic        vdp_ready;
  logic        flash_ready;

  logic        cpu_mem_ready;
  logic [31:0] cpu_rdata;
  logic        bus_error;
  logic        busy;

  // CPU and targets side
  modport master (
    output cpu_mem_valid, cpu_wstrb,
    output cpu_ram_en, vdp_en, status_en, dsp_en, pad_en, cop_ram_write_en, flash_read_en,
    output cpu_ram_rdata, status_rdata, flash_rdata, vdp_rdata, dsp_rdata, pad_rdata,
    output vdp_ready, flash_ready,
    input  cpu_mem_ready, cpu_rdata, bus_error, busy
  );

  // Responder side
  modport slave (
    input  cpu_mem_valid, cpu_wstrb,
    input  cpu_ram_en, vdp_en, status_en, dsp_en, pad_en, cop_ram_write_en, flash_read_en,
    input  cpu_ram_rdata, status_rdata, flash_rdata, vdp_rdata, dsp_rdata, pad_rdata,
    input  vdp_ready, flash_ready,
    output cpu_mem_ready, cpu_rdata, bus_error, busy
  );
endinterface

// File: rtl/cpu_bus_responder.sv
// CPU bus responder: accepts one access at a time, waits either a fixed
// latency (BRAM-class targets) or for a handshake strobe (VDP, flash) with a
// timeout, then returns a one-cycle ready with data, followed by a recovery
// cycle so a held valid is not accepted twice.
module cpu_bus_responder #(
  parameter int unsigned FIXED_LATENCY  = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                clk,
  input logic                reset_n,
  cpu_bus_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FIXED,
    WAIT_EXT,
    RESPOND,
    RECOVER
  } state_t;

  typedef enum logic [2:0] {
    T_NONE,
    T_FLASH,
    T_RAM,
    T_VDP,
    T_STATUS,
    T_DSP,
    T_PAD,
    T_COP
  } target_t;

  // Counter value on the last wait cycle of each wait state.
  localparam logic [7:0] FIX_LAST = 8'(FIXED_LATENCY - 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  target_t     target;
  logic        is_write;
  logic [7:0]  wait_cnt;

  target_t     accept_target;
  logic [31:0] fixed_rdata;
  logic        ext_strobe;
  logic [31:0] ext_rdata;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Priority pick among the selects at accept; unmapped when none is set.
  always_comb begin
    accept_target = T_NONE;
    if (bus.flash_read_en)         accept_target = T_FLASH;
    else if (bus.cpu_ram_en)       accept_target = T_RAM;
    else if (bus.vdp_en)           accept_target = T_VDP;
    else if (bus.status_en)        accept_target = T_STATUS;
    else if (bus.dsp_en)           accept_target = T_DSP;
    else if (bus.pad_en)           accept_target = T_PAD;
    else if (bus.cop_ram_write_en) accept_target = T_COP;
  end

  // Zero-extended read data of the latched fixed-latency target.
  always_comb begin
    fixed_rdata = '0;
    case (target)
      T_RAM:    fixed_rdata = bus.cpu_ram_rdata;
      T_STATUS: fixed_rdata = bus.status_rdata;
      T_DSP:    fixed_rdata = {16'h0000, bus.dsp_rdata};
      T_PAD:    fixed_rdata = {30'h0, bus.pad_rdata};
      default:  fixed_rdata = '0;
    endcase
  end

  // Strobe and data of the latched handshaked target only; the other
  // target's strobe never completes the access.
  always_comb begin
    ext_strobe = 1'b0;
    ext_rdata  = '0;
    if (target == T_FLASH) begin
      ext_strobe = bus.flash_ready;
      ext_rdata  = bus.flash_rdata;
    end else if (target == T_VDP) begin
      ext_strobe = bus.vdp_ready;
      ext_rdata  = {16'h0000, bus.vdp_rdata};
    end
  end

  // Busy whenever a transaction is in flight, including recovery.
  assign bus.busy = (state != IDLE);

  // Transaction FSM with registered ready, data and error outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state             <= IDLE;
      target            <= T_NONE;
      is_write          <= 1'b0;
      wait_cnt          <= 8'd0;
      bus.cpu_mem_ready <= 1'b0;
      bus.cpu_rdata     <= '0;
      bus.bus_error     <= 1'b0;
    end else begin
      // Response outputs are single-cycle pulses; data is zero otherwise.
      bus.cpu_mem_ready <= 1'b0;
      bus.cpu_rdata     <= '0;
      bus.bus_error     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_mem_valid) begin
            target   <= accept_target;
            is_write <= |bus.cpu_wstrb;
            wait_cnt <= 8'd0;
            if (accept_target == T_FLASH || accept_target == T_VDP) state <= WAIT_EXT;
            else                                                      state <= WAIT_FIXED;
          end
        end
        WAIT_FIXED: begin
          if (wait_cnt == FIX_LAST) begin
            state             <= RESPOND;
            bus.cpu_mem_ready <= 1'b1;
            bus.cpu_rdata     <= is_write ? 32'h0 : fixed_rdata;
            bus.bus_error     <= (target == T_NONE);
          end else begin
            wait_cnt <= sat_inc(wait_cnt);
          end
        end
        WAIT_EXT: begin
          // A strobe on the timeout cycle takes precedence over the timeout.
          if (ext_strobe) begin
            state             <= RESPOND;
            bus.cpu_mem_ready <= 1'b1;
            bus.cpu_rdata     <= is_write ? 32'h0 : ext_rdata;
          end else if (wait_cnt == TMO_LAST) begin
            state             <= RESPOND;
            bus.cpu_mem_ready <= 1'b1;
            bus.cpu_rdata     <= 32'hFFFF_FFFF;
            bus.bus_error     <= 1'b1;
          end else begin
            wait_cnt <= sat_inc(wait_cnt);
          end
        end
        RESPOND: begin
          state <= RECOVER;
        end
        RECOVER: begin
          state  <= IDLE;
          target <= T_NONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
